ram_read_port_adapter: RTL and testbench



---
 rtl/ram_read_port_adapter.sv | 116 +++++++++++
 tb/tb_ram_read_port_adapter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_port_adapter.sv
// ram_read_port_adapter: turns a valid/ready read-request stream into raw RAM
// read strobes, tracks the fixed RAM read latency, and captures returning data
// into a first-word-fall-through response FIFO presented as a valid/ready stream.
// Credits (in-flight reads + FIFO entries) bound issue so returning data always
// has a FIFO slot, even under indefinite downstream backpressure.
module ram_read_port_adapter #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  aclk,
    input  logic                  areset,
    // request stream
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    // response stream
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    // raw RAM read port
    output logic                  mem_rden,
    output logic [ADDR_WIDTH-1:0] mem_rdaddr,
    input  logic [DATA_WIDTH-1:0] mem_rddata,
    // credits in use
    output logic [CNT_WIDTH-1:0]  occupancy
);

    localparam int unsigned          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

    // latency tracker: one valid bit per outstanding RAM read stage
    logic [RD_LATENCY-1:0] lat_q, lat_d;
    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;

    // response FIFO state
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic [CNT_WIDTH-1:0]  occ_c;
    logic                  issue_c;
    logic                  push_c;
    logic                  pop_c;

    // Handshake and credit decode; all terms come from registers except the
    // request valid, so s_ready never depends on s_valid.
    always_comb begin
        occ_c      = inflight_q + count_q;
        s_ready    = ~areset & (occ_c < DEPTH_C);
        issue_c    = s_valid & s_ready;
        mem_rden   = issue_c;
        mem_rdaddr = s_addr;
        push_c     = lat_q[RD_LATENCY-1];
        m_valid    = (count_q != '0);
        m_data     = fifo_q[rd_ptr_q];
        pop_c      = m_valid & m_ready;
        occupancy  = occ_c;
    end

    // Next-state for tracker, counters and pointers.
    always_comb begin
        lat_d      = lat_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        lat_d[0] = issue_c;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            lat_d[i] = lat_q[i-1];
        end

        inflight_d = inflight_q + CNT_WIDTH'(issue_c) - CNT_WIDTH'(push_c);
        count_d    = count_q + CNT_WIDTH'(push_c) - CNT_WIDTH'(pop_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Control state registers; reset abandons anything in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lat_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            lat_q      <= lat_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; captures RAM data when the tracker's last stage is valid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= mem_rddata;
        end
    end

endmodule

// File: tb/tb_ram_read_port_adapter.sv
// Bench for ram_read_port_adapter with a 2-cycle RAM model and a scoreboard.
module tb_ram_read_port_adapter;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          aclk;
    logic          areset;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          mem_rden;
    logic [AW-1:0] mem_rdaddr;
    logic [DW-1:0] mem_rddata;
    logic [CW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] p1, p2;
    logic [DW-1:0] exp_q [$];

    ram_read_port_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .mem_rden(mem_rden), .mem_rdaddr(mem_rdaddr), .mem_rddata(mem_rddata),
        .occupancy(occupancy)
    );

    always #5 aclk = ~aclk;

    // RAM with 2-cycle read latency; garbage when not reading
    always @(posedge aclk) begin
        p1 <= mem_rden ? ram[mem_rdaddr] : 64'h0BAD_0BAD_0BAD_0BAD;
        p2 <= p1;
    end
    assign mem_rddata = p2;

    // Scoreboard monitor: queue size is the expected credit count
    always @(negedge aclk) begin
        if (!areset) begin
            checks++;
            if (occupancy !== CW'(exp_q.size())) begin
                errors++;
                $display("FAIL sb_occupancy actual=%0d required=%0d t=%0t", occupancy, exp_q.size(), $time);
            end
            checks++;
            if (s_ready !== (exp_q.size() < DEPTH)) begin
                errors++;
                $display("FAIL sb_s_ready actual=%0b required=%0b t=%0t", s_ready, exp_q.size() < DEPTH, $time);
            end
            checks++;
            if (mem_rden !== (s_valid & s_ready) || (mem_rden && mem_rdaddr !== s_addr)) begin
                errors++;
                $display("FAIL sb_issue rden=%0b addr=%0h required rden=%0b addr=%0h", mem_rden, mem_rdaddr, s_valid & s_ready, s_addr);
            end
            if (dut.lat_q[1]) begin
                checks++;
                if (dut.count_q == CW'(DEPTH)) begin
                    errors++;
                    $display("FAIL sb_overflow push with count=%0d required<%0d", dut.count_q, DEPTH);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected data=%0h required=no response t=%0t", m_data, $time);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL sb_data actual=%0h required=%0h t=%0t", m_data, e, $time);
                    end
                end
            end
            if (s_valid && s_ready) exp_q.push_back(ram[s_addr]);
        end
    end

    task automatic test_reset();
        s_valid = 1'b1;
        s_addr  = 9'h003;
        m_ready = 1'b1;
        areset  = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (s_ready !== 1'b0 || mem_rden !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_vals s_ready=%0b rden=%0b m_valid=%0b m_data=%0h occ=%0d required all 0",
                     s_ready, mem_rden, m_valid, m_data, occupancy);
        end
        @(posedge aclk); #1;
        areset  = 1'b0;
        s_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release s_ready actual=%0b required=1", s_ready);
        end
    endtask

    task automatic test_single();
        int occ_exp [4] = '{1, 1, 1, 0};
        ram[5] = 64'hDEAD_BEEF_0000_0001;
        m_ready = 1'b1;
        @(posedge aclk); #1;
        s_valid = 1'b1;
        s_addr  = 9'h005;
        @(negedge aclk);
        checks++;
        if (mem_rden !== 1'b1 || mem_rdaddr !== 9'h005) begin
            errors++;
            $display("FAIL single_issue rden=%0b addr=%0h required rden=1 addr=5", mem_rden, mem_rdaddr);
        end
        @(posedge aclk); #1;
        s_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge aclk);
            checks++;
            if (occupancy !== CW'(occ_exp[k-1]) || m_valid !== (k == 3)) begin
                errors++;
                $display("FAIL single_T+%0d occ=%0d m_valid=%0b required occ=%0d m_valid=%0b",
                         k, occupancy, m_valid, occ_exp[k-1], k == 3);
            end
            if (k == 3) begin
                checks++;
                if (m_data !== 64'hDEAD_BEEF_0000_0001) begin
                    errors++;
                    $display("FAIL single_data actual=%0h required=deadbeef00000001", m_data);
                end
            end
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        int n     = 0;
        int drops = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge aclk); #1;
            s_valid = (c < 16);
            s_addr  = AW'(c);
            @(negedge aclk);
            if (c < 16 && !s_ready) drops++;
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL stream_s_ready drops=%0d required=0", drops);
        end
        checks++;
        if (n != 16 || first != 3 || last != 18) begin
            errors++;
            $display("FAIL stream_resp n=%0d first=%0d last=%0d required n=16 first=3 last=18", n, first, last);
        end
    endtask

    task automatic test_backpressure_release();
        int acc = 0;
        int w;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge aclk); #1;
            s_valid = 1'b1;
            s_addr  = AW'(9'h020 + c);
            @(negedge aclk);
            if (s_valid && s_ready) acc++;
        end
        checks++;
        if (acc != 4 || s_ready !== 1'b0 || occupancy !== CW'(4)) begin
            errors++;
            $display("FAIL bp_full acc=%0d s_ready=%0b occ=%0d required acc=4 s_ready=0 occ=4", acc, s_ready, occupancy);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== ram[9'h020]) begin
            errors++;
            $display("FAIL bp_head m_valid=%0b data=%0h required m_valid=1 data=%0h", m_valid, m_data, ram[9'h020]);
        end
        // one-cycle release
        @(posedge aclk); #1;
        m_ready = 1'b1;
        s_addr  = 9'h040;
        @(negedge aclk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_pop_cycle s_ready=%0b required=0", s_ready);
        end
        @(posedge aclk); #1;
        m_ready = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_accept s_ready=%0b required=1", s_ready);
        end
        @(posedge aclk); #1;
        s_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if (occupancy !== CW'(4) || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_refull occ=%0d s_ready=%0b required occ=4 s_ready=0", occupancy, s_ready);
        end
        m_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge aclk);
            w++;
        end
        @(posedge aclk); #1;
        checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_drain pending=%0d m_valid=%0b required 0 0", exp_q.size(), m_valid);
        end
    endtask

    task automatic test_random();
        int w;
        for (int c = 0; c < 10000; c++) begin
            @(posedge aclk); #1;
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_addr  = AW'($urandom);
        end
        @(posedge aclk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge aclk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int lat = -1;
        @(posedge aclk); #1;
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_valid = 1'b1;
            s_addr  = AW'(9'h100 + c);
            @(posedge aclk); #1;
        end
        s_valid = 1'b0;
        checks++;
        if (occupancy !== CW'(4) || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup occ=%0d m_valid=%0b required occ=4 m_valid=1", occupancy, m_valid);
        end
        areset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (m_valid !== 1'b0 || occupancy !== '0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset m_valid=%0b occ=%0d s_ready=%0b required 0 0 0", m_valid, occupancy, s_ready);
        end
        @(posedge aclk); #1;
        areset  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_late m_valid=%0b data=%0h required m_valid=0", m_valid, m_data);
            end
        end
        ram[9'h077] = 64'h1234_5678_9ABC_DEF0;
        @(posedge aclk); #1;
        s_valid = 1'b1;
        s_addr  = 9'h077;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            if (m_valid && lat < 0) begin
                lat = k;
                checks++;
                if (m_data !== 64'h1234_5678_9ABC_DEF0) begin
                    errors++;
                    $display("FAIL post_reset_data actual=%0h required=123456789abcdef0", m_data);
                end
            end
            @(posedge aclk); #1;
            s_valid = 1'b0;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL post_reset_latency actual=%0d required=3", lat);
        end
    endtask

    initial begin
        aclk    = 1'b0;
        areset  = 1'b1;
        s_valid = 1'b0;
        s_addr  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = {32'hC0DE_0000 | 32'(i), $urandom};
        end
        test_reset();
        test_single();
        test_stream();
        test_backpressure_release();
        test_random();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_pending actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
